// File: rtl/tug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tug_pkg
// Description : Shared types and helpers for the tug-of-war playfield.
// Revision    : 1.0 - initial release
// ============================================================================
package tug_pkg;

    // Playfield phases: live play, post-round blank hold, match finished
    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        OVER = 2'd2
    } tug_state_t;

    // Index of the middle LED of an odd-width row
    function automatic int center(int n);
        return (n - 1) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/press_edge.sv
`default_nettype none
// ============================================================================
// Module      : press_edge
// Description : Rising-edge detector turning a synchronised key level into a
//               single-cycle press strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module press_edge (
    input  logic Clock,
    input  logic Reset,
    input  logic in,
    output logic press
);

    logic r_q;

    // Previous key level; it keeps sampling during Reset so a key held
    // through Reset is not mistaken for a fresh press afterwards.
    always_ff @(posedge Clock) begin
        r_q <= in;
    end

    assign press = in & ~r_q & ~Reset;

endmodule
`default_nettype wire

// File: rtl/tug_field.sv
`default_nettype none
// ============================================================================
// Module      : tug_field
// Description : Tug-of-war playfield. One lit LED moves left/right on key
//               presses; pulling past an end LED wins a round, scores are
//               kept per player and the match latches once a player reaches
//               WIN_SCORE round wins.
// Revision    : 1.0 - initial release
// ============================================================================
module tug_field
    import tug_pkg::*;
#(
    parameter int NUM_LIGHTS  = 9,
    parameter int SCORE_W     = 3,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  L,
    input  logic                  R,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic                  round_L,
    output logic                  round_R,
    output logic [SCORE_W-1:0]    score_L,
    output logic [SCORE_W-1:0]    score_R,
    output logic                  match_over,
    output logic                  winner_L
);

    localparam int                    c_POS_W     = $clog2(NUM_LIGHTS);
    localparam int                    c_HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_POS_W-1:0]    c_CENTER    = c_POS_W'(center(NUM_LIGHTS));
    localparam logic [c_POS_W-1:0]    c_LAST      = c_POS_W'(NUM_LIGHTS - 1);
    localparam logic [SCORE_W-1:0]    c_WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [c_HOLD_W-1:0]   c_HOLD_INIT = c_HOLD_W'(HOLD_CYCLES);

    // One-hot decode of a playfield position
    function automatic logic [NUM_LIGHTS-1:0] decode(input logic [c_POS_W-1:0] p);
        logic [NUM_LIGHTS-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            d[i] = (p == c_POS_W'(i));
        end
        return d;
    endfunction

    tug_state_t            r_state, w_state_nx;
    logic [c_POS_W-1:0]    r_pos, w_pos_nx;
    logic [c_HOLD_W-1:0]   r_hold, w_hold_nx;
    logic [SCORE_W-1:0]    r_score_L, r_score_R, w_score_L_nx, w_score_R_nx;
    logic [SCORE_W-1:0]    w_score_L_inc, w_score_R_inc;
    logic [NUM_LIGHTS-1:0] r_lights, w_lights_nx;
    logic                  r_round_L, r_round_R, r_match_over, r_winner_L;
    logic                  w_round_L_nx, w_round_R_nx, w_match_nx, w_winner_nx;
    logic                  w_press_L, w_press_R, w_pull_L, w_pull_R;
    logic                  w_win_L, w_win_R, w_match_end;

    press_edge u_edge_L (.Clock(Clock), .Reset(Reset), .in(L), .press(w_press_L));
    press_edge u_edge_R (.Clock(Clock), .Reset(Reset), .in(R), .press(w_press_R));

    // Simultaneous presses cancel; a pull beyond an end LED is a round win
    assign w_pull_L      = w_press_L & ~w_press_R;
    assign w_pull_R      = w_press_R & ~w_press_L;
    assign w_win_L       = (r_state == PLAY) && w_pull_L && (r_pos == c_LAST);
    assign w_win_R       = (r_state == PLAY) && w_pull_R && (r_pos == '0);
    assign w_score_L_inc = r_score_L + SCORE_W'(1);
    assign w_score_R_inc = r_score_R + SCORE_W'(1);
    assign w_match_end   = (w_win_L && (w_score_L_inc == c_WIN)) ||
                           (w_win_R && (w_score_R_inc == c_WIN));

    // State and datapath registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= PLAY;
            r_pos        <= c_CENTER;
            r_hold       <= '0;
            r_score_L    <= '0;
            r_score_R    <= '0;
            r_lights     <= decode(c_CENTER);
            r_round_L    <= 1'b0;
            r_round_R    <= 1'b0;
            r_match_over <= 1'b0;
            r_winner_L   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_pos        <= w_pos_nx;
            r_hold       <= w_hold_nx;
            r_score_L    <= w_score_L_nx;
            r_score_R    <= w_score_R_nx;
            r_lights     <= w_lights_nx;
            r_round_L    <= w_round_L_nx;
            r_round_R    <= w_round_R_nx;
            r_match_over <= w_match_nx;
            r_winner_L   <= w_winner_nx;
        end
    end

    // Next state: move the light, score round wins, run the hold countdown
    always_comb begin
        w_state_nx   = r_state;
        w_pos_nx     = r_pos;
        w_hold_nx    = r_hold;
        w_score_L_nx = r_score_L;
        w_score_R_nx = r_score_R;
        case (r_state)
            PLAY: begin
                if (w_win_L || w_win_R) begin
                    if (w_win_L) w_score_L_nx = w_score_L_inc;
                    if (w_win_R) w_score_R_nx = w_score_R_inc;
                    w_state_nx = w_match_end ? OVER : HOLD;
                    w_hold_nx  = c_HOLD_INIT;
                end else if (w_pull_L) begin
                    w_pos_nx = r_pos + c_POS_W'(1);
                end else if (w_pull_R) begin
                    w_pos_nx = r_pos - c_POS_W'(1);
                end
            end
            HOLD: begin
                w_hold_nx = r_hold - c_HOLD_W'(1);
                if (w_hold_nx == '0) begin
                    w_state_nx = PLAY;
                    w_pos_nx   = c_CENTER;
                end
            end
            OVER: begin
                w_state_nx = OVER;
            end
            default: begin
                w_state_nx = PLAY;
                w_pos_nx   = c_CENTER;
                w_hold_nx  = '0;
            end
        endcase
    end

    // Next outputs: blank row while holding, win pulses, sticky match result
    always_comb begin
        w_lights_nx  = (w_state_nx == HOLD) ? '0 : decode(w_pos_nx);
        w_round_L_nx = w_win_L;
        w_round_R_nx = w_win_R;
        w_match_nx   = r_match_over | w_match_end;
        w_winner_nx  = w_match_end ? w_win_L : r_winner_L;
    end

    assign lights     = r_lights;
    assign round_L    = r_round_L;
    assign round_R    = r_round_R;
    assign score_L    = r_score_L;
    assign score_R    = r_score_R;
    assign match_over = r_match_over;
    assign winner_L   = r_winner_L;

endmodule
`default_nettype wire

// File: tb/tb_tug_field.sv
`default_nettype none
// ============================================================================
// Module      : tb_tug_field
// Description : Directed scoreboard bench for tug_field. Three instances:
//               default build, a WIN_SCORE=2 build and a 3-LED/1-cycle-hold
//               build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tug_field;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic       rst0 = 1'b1, l0 = 1'b0, r0 = 1'b0;
    logic       rst1 = 1'b1, l1 = 1'b0, r1 = 1'b0;
    logic       rst2 = 1'b1, l2 = 1'b0, r2 = 1'b0;
    logic [8:0] lt0, lt1;
    logic [2:0] lt2;
    logic       rl0, rr0, mo0, wl0, rl1, rr1, mo1, wl1, rl2, rr2, mo2, wl2;
    logic [2:0] sl0, sr0, sl1, sr1, sl2, sr2;

    tug_field #(.NUM_LIGHTS(9), .SCORE_W(3), .WIN_SCORE(7), .HOLD_CYCLES(4)) u_dut0 (
        .Clock(Clock), .Reset(rst0), .L(l0), .R(r0), .lights(lt0),
        .round_L(rl0), .round_R(rr0), .score_L(sl0), .score_R(sr0),
        .match_over(mo0), .winner_L(wl0));

    tug_field #(.NUM_LIGHTS(9), .SCORE_W(3), .WIN_SCORE(2), .HOLD_CYCLES(4)) u_dut1 (
        .Clock(Clock), .Reset(rst1), .L(l1), .R(r1), .lights(lt1),
        .round_L(rl1), .round_R(rr1), .score_L(sl1), .score_R(sr1),
        .match_over(mo1), .winner_L(wl1));

    tug_field #(.NUM_LIGHTS(3), .SCORE_W(3), .WIN_SCORE(7), .HOLD_CYCLES(1)) u_dut2 (
        .Clock(Clock), .Reset(rst2), .L(l2), .R(r2), .lights(lt2),
        .round_L(rl2), .round_R(rr2), .score_L(sl2), .score_R(sr2),
        .match_over(mo2), .winner_L(wl2));

    // Observation word: {lights[8:0], round_L, round_R, score_L, score_R, match_over, winner_L}
    typedef struct {
        string       tag;
        int          id;
        logic [18:0] exp;
    } sb_t;

    sb_t q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    function automatic logic [18:0] observe(input int id);
        case (id)
            0:       return {lt0, rl0, rr0, sl0, sr0, mo0, wl0};
            1:       return {lt1, rl1, rr1, sl1, sr1, mo1, wl1};
            default: return {6'b0, lt2, rl2, rr2, sl2, sr2, mo2, wl2};
        endcase
    endfunction

    // Drive one cycle of inputs to one instance, queue what it must show after
    // the next clock edge, then pop and check once it has produced it.
    task automatic step(input int id, input logic rst, input logic l, input logic r,
                        input logic [8:0] elt, input logic erl, input logic err,
                        input logic [2:0] esl, input logic [2:0] esr,
                        input logic emo, input logic ewl, input string tag);
        sb_t         e;
        logic [18:0] obs;
        case (id)
            0:       begin rst0 = rst; l0 = l; r0 = r; end
            1:       begin rst1 = rst; l1 = l; r1 = r; end
            default: begin rst2 = rst; l2 = l; r2 = r; end
        endcase
        q.push_back('{tag: tag, id: id, exp: {elt, erl, err, esl, esr, emo, ewl}});
        @(posedge Clock);
        #1;
        e   = q.pop_front();
        obs = observe(e.id);
        n_cmp++;
        assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    initial begin
        // ---------------- default instance ----------------
        step(0, 1, 1, 0, 9'h010, 0, 0, 0, 0, 0, 0, "d0_reset");
        step(0, 0, 1, 0, 9'h010, 0, 0, 0, 0, 0, 0, "d0_held_thru_reset");
        step(0, 0, 0, 0, 9'h010, 0, 0, 0, 0, 0, 0, "d0_release");
        // L held three cycles moves once
        step(0, 0, 1, 0, 9'h020, 0, 0, 0, 0, 0, 0, "d0_hold_L_1");
        step(0, 0, 1, 0, 9'h020, 0, 0, 0, 0, 0, 0, "d0_hold_L_2");
        step(0, 0, 1, 0, 9'h020, 0, 0, 0, 0, 0, 0, "d0_hold_L_3");
        step(0, 0, 0, 0, 9'h020, 0, 0, 0, 0, 0, 0, "d0_hold_L_rel");
        // simultaneous presses cancel
        step(0, 1, 0, 0, 9'h010, 0, 0, 0, 0, 0, 0, "d0_reset2");
        step(0, 0, 1, 1, 9'h010, 0, 0, 0, 0, 0, 0, "d0_both");
        step(0, 0, 0, 0, 9'h010, 0, 0, 0, 0, 0, 0, "d0_both_rel");
        // walk to the left end; reaching bit 8 is not a win
        for (int p = 5; p <= 8; p++) begin
            step(0, 0, 1, 0, 9'(1 << p), 0, 0, 0, 0, 0, 0, "d0_walk_L");
            step(0, 0, 0, 0, 9'(1 << p), 0, 0, 0, 0, 0, 0, "d0_walk_L_rel");
        end
        step(0, 0, 1, 0, 9'h000, 1, 0, 1, 0, 0, 0, "d0_win_L");
        step(0, 0, 0, 0, 9'h000, 0, 0, 1, 0, 0, 0, "d0_hold_2");
        step(0, 0, 1, 0, 9'h000, 0, 0, 1, 0, 0, 0, "d0_hold_press");
        step(0, 0, 0, 0, 9'h000, 0, 0, 1, 0, 0, 0, "d0_hold_4");
        step(0, 0, 0, 0, 9'h010, 0, 0, 1, 0, 0, 0, "d0_recentre");
        step(0, 0, 1, 0, 9'h020, 0, 0, 1, 0, 0, 0, "d0_after_hold");
        step(0, 0, 0, 0, 9'h020, 0, 0, 1, 0, 0, 0, "d0_after_hold_rel");
        // walk to the right end and win a round there
        for (int p = 4; p >= 0; p--) begin
            step(0, 0, 0, 1, 9'(1 << p), 0, 0, 1, 0, 0, 0, "d0_walk_R");
            step(0, 0, 0, 0, 9'(1 << p), 0, 0, 1, 0, 0, 0, "d0_walk_R_rel");
        end
        step(0, 0, 0, 1, 9'h000, 0, 1, 1, 1, 0, 0, "d0_win_R");
        step(0, 1, 0, 0, 9'h010, 0, 0, 0, 0, 0, 0, "d0_reset_in_hold");
        step(0, 0, 0, 0, 9'h010, 0, 0, 0, 0, 0, 0, "d0_post_reset");

        // ---------------- WIN_SCORE=2 instance ----------------
        step(1, 1, 0, 0, 9'h010, 0, 0, 0, 0, 0, 0, "d1_reset");
        for (int rnd = 1; rnd <= 2; rnd++) begin
            for (int p = 3; p >= 0; p--) begin
                step(1, 0, 0, 1, 9'(1 << p), 0, 0, 0, 3'(rnd - 1), 0, 0, "d1_walk_R");
                step(1, 0, 0, 0, 9'(1 << p), 0, 0, 0, 3'(rnd - 1), 0, 0, "d1_walk_R_rel");
            end
            if (rnd == 1) begin
                step(1, 0, 0, 1, 9'h000, 0, 1, 0, 1, 0, 0, "d1_win_R1");
                step(1, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, "d1_hold_2");
                step(1, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, "d1_hold_3");
                step(1, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, "d1_hold_4");
                step(1, 0, 0, 0, 9'h010, 0, 0, 0, 1, 0, 0, "d1_recentre");
            end else begin
                step(1, 0, 0, 1, 9'h001, 0, 1, 0, 2, 1, 0, "d1_match");
            end
        end
        step(1, 0, 0, 0, 9'h001, 0, 0, 0, 2, 1, 0, "d1_over_idle");
        step(1, 0, 1, 0, 9'h001, 0, 0, 0, 2, 1, 0, "d1_over_L");
        step(1, 0, 0, 0, 9'h001, 0, 0, 0, 2, 1, 0, "d1_over_L_rel");
        step(1, 0, 0, 1, 9'h001, 0, 0, 0, 2, 1, 0, "d1_over_R");
        step(1, 0, 0, 0, 9'h001, 0, 0, 0, 2, 1, 0, "d1_over_R_rel");
        step(1, 1, 0, 0, 9'h010, 0, 0, 0, 0, 0, 0, "d1_reset_in_over");
        step(1, 0, 0, 0, 9'h010, 0, 0, 0, 0, 0, 0, "d1_post_reset");

        // ---------------- 3-LED, 1-cycle hold instance ----------------
        step(2, 1, 0, 0, 9'h002, 0, 0, 0, 0, 0, 0, "d2_reset");
        step(2, 0, 0, 1, 9'h001, 0, 0, 0, 0, 0, 0, "d2_R1");
        step(2, 0, 0, 0, 9'h001, 0, 0, 0, 0, 0, 0, "d2_R1_rel");
        step(2, 0, 0, 1, 9'h000, 0, 1, 0, 1, 0, 0, "d2_win_R");
        step(2, 0, 0, 0, 9'h002, 0, 0, 0, 1, 0, 0, "d2_recentre_R");
        step(2, 0, 1, 0, 9'h004, 0, 0, 0, 1, 0, 0, "d2_L1");
        step(2, 0, 0, 0, 9'h004, 0, 0, 0, 1, 0, 0, "d2_L1_rel");
        step(2, 0, 1, 0, 9'h000, 1, 0, 1, 1, 0, 0, "d2_win_L");
        step(2, 0, 0, 0, 9'h002, 0, 0, 1, 1, 0, 0, "d2_recentre_L");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
